lsu_riscv: RTL and testbench
============================

LSU_RISCV -- requirements
Module: lsu_riscv

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk_i in 1, rising-edge clock; rst_i in 1, asynchronous active-high reset.
REQ-002 lsu_req_i  in  1  core requests a memory access; held high while lsu_stall_req_o=1.
REQ-003 lsu_we_i  in  1  1 = store, 0 = load.
REQ-004 lsu_size_i  in  3  LDST code: 0=B, 1=H, 2=W, 4=BU, 5=HU; 3, 6 and 7 are illegal.
REQ-005 lsu_addr_i  in  32  byte address from the ALU.
REQ-006 lsu_data_i  in  32  store data (rs2).
REQ-007 lsu_data_o  out  32  extended load result for writeback.
REQ-008 lsu_stall_req_o  out  1  freezes the core pipeline.
REQ-009 misaligned_o  out  1  one-cycle exception pulse.
REQ-010 data_req_o  out  1  memory request valid.
REQ-011 data_we_o  out  1  memory write enable.
REQ-012 data_be_o  out  4  byte enables.
REQ-013 data_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-014 data_wdata_o  out  32  lane-replicated store data.
REQ-015 data_gnt_i  in  1  memory accepts the request.
REQ-016 data_rvalid_i  in  1  memory response or read data valid.
REQ-017 data_rdata_i  in  32  memory read word.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT_GNT, WAIT_RVALID and DONE.
REQ-019 IDLE with lsu_req_i=1 and a legal, aligned access: capture addr, we, size and wdata into registers; go to WAIT_GNT.
REQ-020 IDLE with lsu_req_i=1 and an illegal size, H/HU with addr[0]=1, or W with addr[1:0]!=0: no memory transaction; go to DONE with the error flag set.
REQ-021 WAIT_GNT: data_req_o=1 from the captured registers.
- data_gnt_i=1 on a load: go to WAIT_RVALID.
- data_gnt_i=1 on a store: go to DONE.
- data_gnt_i=0: stay in WAIT_GNT; the request is held stable.
REQ-022 WAIT_RVALID: data_req_o=0; on data_rvalid_i=1, register the extended load data into lsu_data_o and go to DONE.
REQ-023 DONE: unconditionally return to IDLE; misaligned_o=1 in DONE only when the error flag is set.
REQ-024 lsu_stall_req_o = lsu_req_i AND (state != DONE), combinational, so the core advances exactly once, in the DONE cycle.
REQ-025 Minimum latency: a load issued in cycle 0 with gnt in cycle 1 and rvalid in cycle 2 reaches DONE in cycle 3 (stall low in cycle 3); a store with gnt in cycle 1 reaches DONE in cycle 2.
REQ-026 data_be_o:
- B/BU: 4'b0001 shifted left by addr[1:0].
- H/HU: 4'b0011 shifted left by addr[1:0].
- W: 4'b1111.
- 0 whenever data_req_o=0.
REQ-027 data_wdata_o: B is {4{wdata[7:0]}}, H is {2{wdata[15:0]}}, W is wdata.
REQ-028 Load extension:
- Select the byte or halfword lane by the captured addr[1:0].
- B/H are sign-extended; BU/HU are zero-extended; W is passed through.
REQ-029 lsu_data_o SHALL hold its value until the next successful load; stores and errors leave it unchanged.
REQ-030 data_rvalid_i outside WAIT_RVALID and data_gnt_i outside WAIT_GNT SHALL be ignored.
REQ-031 The memory never asserts rvalid in the same cycle as the gnt that it answers; the block need not accept that case.
REQ-032 A new request SHALL be accepted only in IDLE, so at most one transaction is ever outstanding.

Reset
REQ-033 rst_i=1 SHALL asynchronously force state=IDLE and clear the capture registers and the error flag.
REQ-034 During reset: lsu_data_o=0, misaligned_o=0, data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0.
REQ-035 Reset asserted mid-transaction SHALL abandon that transaction; a late gnt or rvalid arriving after reset release SHALL be ignored.

Verification
REQ-036 LB, addr=0x103, rdata=0x80FF_0000, gnt in cycle 1, rvalid in cycle 2 -> data_be_o=0001 shifted by 3 (4'b1000), lsu_data_o=0xFFFF_FF80, stall low in cycle 3 only.
REQ-037 SH, addr=0x202, wdata=0x1234_ABCD, gnt delayed 3 cycles -> data_req_o held 4 cycles with addr 0x200, be=1100, wdata=0xABCD_ABCD; stall releases one cycle after gnt.
REQ-038 LHU, addr=0x002, rdata=0x8001_0000 -> lsu_data_o=0x0000_8001; the same access as LH -> 0xFFFF_8001.
REQ-039 LW, addr=0x006 -> data_req_o never asserted, misaligned_o=1 in cycle 1, lsu_data_o unchanged.
REQ-040 Load with gnt, then rst_i pulsed before rvalid, then a stray rvalid -> all outputs 0, state IDLE, lsu_data_o stays 0.
REQ-041 Back-to-back SW then LW with lsu_req_i held high -> exactly two data_req_o transactions, no duplicate issue.

Source files
------------

// File: rtl/lsu_riscv_if.sv
// Core-side and memory-side signal bundle of the load/store unit.
// The slave modport is the LSU; the master modport is the core plus the data memory.
interface lsu_riscv_if;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        misaligned_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    modport slave (
        input  lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i,
        input  data_gnt_i, data_rvalid_i, data_rdata_i,
        output lsu_data_o, lsu_stall_req_o, misaligned_o,
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o
    );

    modport master (
        output lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i,
        output data_gnt_i, data_rvalid_i, data_rdata_i,
        input  lsu_data_o, lsu_stall_req_o, misaligned_o,
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o
    );
endinterface

// File: rtl/lsu_riscv.sv
// RISC-V load/store unit: one outstanding gnt/rvalid transaction, byte-lane steering,
// load sign/zero extension and misaligned-access detection with a core stall request.
module lsu_riscv (
    input  logic        clk_i,
    input  logic        rst_i,
    lsu_riscv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] data_reg, data_next;
    logic [2:0]  size_reg, size_next;
    logic        we_reg, we_next;
    logic        err_reg, err_next;

    logic        access_bad;
    logic        data_req;
    logic [7:0]  rd_lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [3:0]  be;
    logic [31:0] wdata_rep;

    // Legality of the incoming request, judged on the live inputs before capture.
    always_comb begin
        access_bad = 1'b0;
        case (bus.lsu_size_i)
            3'd0, 3'd4: access_bad = 1'b0;
            3'd1, 3'd5: access_bad = bus.lsu_addr_i[0];
            3'd2:       access_bad = |bus.lsu_addr_i[1:0];
            default:    access_bad = 1'b1;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_lanes[gi] = bus.data_rdata_i[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rd_lanes[addr_reg[1:0]];
    assign half_sel = addr_reg[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];

    always_comb begin
        load_ext = bus.data_rdata_i;
        case (size_reg)
            3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    load_ext = {24'd0, byte_sel};
            3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
            3'd5:    load_ext = {16'd0, half_sel};
            default: load_ext = bus.data_rdata_i;
        endcase
    end

    // size_reg[2] only marks unsigned loads, so the low bits pick the access width.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata_reg;
        case (size_reg[1:0])
            2'd0: begin
                be        = 4'b0001 << addr_reg[1:0];
                wdata_rep = {4{wdata_reg[7:0]}};
            end
            2'd1: begin
                be        = 4'b0011 << addr_reg[1:0];
                wdata_rep = {2{wdata_reg[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_reg;
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        size_next  = size_reg;
        we_next    = we_reg;
        err_next   = err_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (bus.lsu_req_i) begin
                    if (access_bad) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        addr_next  = bus.lsu_addr_i;
                        wdata_next = bus.lsu_data_i;
                        size_next  = bus.lsu_size_i;
                        we_next    = bus.lsu_we_i;
                        err_next   = 1'b0;
                        state_next = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                if (bus.data_gnt_i) begin
                    state_next = we_reg ? DONE : WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (bus.data_rvalid_i) begin
                    data_next  = load_ext;
                    state_next = DONE;
                end
            end
            DONE: begin
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            size_reg  <= '0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            size_reg  <= size_next;
            we_reg    <= we_next;
            err_reg   <= err_next;
            data_reg  <= data_next;
        end
    end

    assign data_req            = (state_reg == WAIT_GNT);
    assign bus.data_req_o      = data_req;
    assign bus.data_we_o       = data_req & we_reg;
    assign bus.data_be_o       = data_req ? be : 4'b0000;
    assign bus.data_addr_o     = {addr_reg[31:2], 2'b00};
    assign bus.data_wdata_o    = wdata_rep;
    assign bus.lsu_data_o      = data_reg;
    assign bus.lsu_stall_req_o = bus.lsu_req_i & (state_reg != DONE);
    assign bus.misaligned_o    = (state_reg == DONE) & err_reg;
endmodule

// File: tb/tb_lsu_riscv.sv
// Scoreboard bench for lsu_riscv: the driver queues expected bus and result records,
// an independent monitor checks them when the DUT issues a request or releases the stall.
module tb_lsu_riscv;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_riscv_if bus ();

    lsu_riscv dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          req_cycles;
    } bus_exp_t;

    typedef struct {
        logic        mis;
        logic [31:0] data;
        int          lat;
    } resp_exp_t;

    bus_exp_t  bus_q [$];
    resp_exp_t resp_q [$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          bus_txn  = 0;
    int          gnt_delay = 0;
    logic [31:0] mem_rdata = '0;
    bit          mem_auto  = 1'b1;
    int          mem_wait  = 0;
    bit          mem_pend  = 1'b0;
    int          mon_lat   = 0;
    int          mon_reqc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: grant after gnt_delay request cycles, answer loads one cycle later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                bus.data_gnt_i    = 1'b0;
                bus.data_rvalid_i = 1'b0;
                if (mem_pend) begin
                    bus.data_rvalid_i = 1'b1;
                    bus.data_rdata_i  = mem_rdata;
                    mem_pend          = 1'b0;
                end
                if (bus.data_req_o) begin
                    if (mem_wait >= gnt_delay) begin
                        bus.data_gnt_i = 1'b1;
                        mem_wait       = 0;
                        mem_pend       = !bus.data_we_o;
                    end else begin
                        mem_wait++;
                    end
                end
            end else begin
                mem_wait = 0;
                mem_pend = 1'b0;
            end
        end
    end

    // Monitor: bus requests against bus_q, completed accesses against resp_q.
    initial begin
        bus_exp_t  be_e;
        resp_exp_t rs_e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_lat  = 0;
                mon_reqc = 0;
            end else begin
                if (bus.data_req_o) begin
                    mon_reqc++;
                    if (bus_q.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        be_e = bus_q[0];
                        check("bus_we", {31'd0, bus.data_we_o}, {31'd0, be_e.we});
                        check("bus_addr", bus.data_addr_o, be_e.addr);
                        check("bus_be", {28'd0, bus.data_be_o}, {28'd0, be_e.be});
                        if (be_e.we) check("bus_wdata", bus.data_wdata_o, be_e.wdata);
                        if (bus.data_gnt_i) begin
                            check("req_cycles", mon_reqc, be_e.req_cycles);
                            void'(bus_q.pop_front());
                            bus_txn++;
                            mon_reqc = 0;
                        end
                    end
                end else begin
                    check("be_idle", {28'd0, bus.data_be_o}, 32'd0);
                end

                if (!bus.lsu_req_i) begin
                    mon_lat = 0;
                end else if (!bus.lsu_stall_req_o) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        rs_e = resp_q.pop_front();
                        check("misaligned", {31'd0, bus.misaligned_o}, {31'd0, rs_e.mis});
                        check("lsu_data", bus.lsu_data_o, rs_e.data);
                        check("latency", mon_lat, rs_e.lat);
                    end
                    mon_lat = 0;
                end else begin
                    check("misaligned_early", {31'd0, bus.misaligned_o}, 32'd0);
                    mon_lat++;
                end
            end
        end
    end

    // Issue one access (caller is just after a rising edge); leaves lsu_req_i high.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic exp_mis, input logic [31:0] exp_data);
        bus_exp_t  b;
        resp_exp_t r;
        bit        done;
        if (!exp_mis) begin
            b.we = we; b.addr = {addr[31:2], 2'b00}; b.be = exp_be;
            b.wdata = exp_wdata; b.req_cycles = delay + 1;
            bus_q.push_back(b);
        end
        r.mis  = exp_mis;
        r.data = exp_data;
        r.lat  = exp_mis ? 1 : (we ? 2 + delay : 3 + delay);
        resp_q.push_back(r);
        gnt_delay      = delay;
        mem_rdata      = rdata;
        bus.lsu_req_i  = 1'b1;
        bus.lsu_we_i   = we;
        bus.lsu_size_i = size;
        bus.lsu_addr_i = addr;
        bus.lsu_data_i = wdata;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!bus.lsu_stall_req_o) done = 1'b1;
        end
        if (!done) check("stall_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.lsu_req_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_req"}, {31'd0, bus.data_req_o}, 32'd0);
        check({tag, "_data_we"}, {31'd0, bus.data_we_o}, 32'd0);
        check({tag, "_data_be"}, {28'd0, bus.data_be_o}, 32'd0);
        check({tag, "_data_addr"}, bus.data_addr_o, 32'd0);
        check({tag, "_data_wdata"}, bus.data_wdata_o, 32'd0);
        check({tag, "_lsu_data"}, bus.lsu_data_o, 32'd0);
        check({tag, "_misaligned"}, {31'd0, bus.misaligned_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int txn_before;
        rst               = 1'b1;
        bus.lsu_req_i     = 1'b0;
        bus.lsu_we_i      = 1'b0;
        bus.lsu_size_i    = 3'd0;
        bus.lsu_addr_i    = '0;
        bus.lsu_data_i    = '0;
        bus.data_gnt_i    = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check("reset_stall", {31'd0, bus.lsu_stall_req_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //     we    size  addr          wdata         dly rdata         be       exp_wdata     mis   lsu_data
        access(1'b0, 3'd0, 32'h0000_0103, 32'h0,        0, 32'h80FF_0000, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80);
        idle();
        access(1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h0,        4'b1100, 32'hABCD_ABCD, 1'b0, 32'hFFFF_FF80);
        idle();
        access(1'b0, 3'd5, 32'h0000_0002, 32'h0,        0, 32'h8001_0000, 4'b1100, 32'h0,        1'b0, 32'h0000_8001);
        idle();
        access(1'b0, 3'd1, 32'h0000_0002, 32'h0,        0, 32'h8001_0000, 4'b1100, 32'h0,        1'b0, 32'hFFFF_8001);
        idle();
        access(1'b0, 3'd2, 32'h0000_0006, 32'h0,        0, 32'hDEAD_BEEF, 4'b0000, 32'h0,        1'b1, 32'hFFFF_8001);
        idle();
        access(1'b0, 3'd3, 32'h0000_0010, 32'h0,        0, 32'hDEAD_BEEF, 4'b0000, 32'h0,        1'b1, 32'hFFFF_8001);
        idle();
        access(1'b1, 3'd1, 32'h0000_0001, 32'h5555_AAAA, 0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'hFFFF_8001);
        idle();
        access(1'b1, 3'd0, 32'h0000_0001, 32'hDEAD_0055, 1, 32'h0,        4'b0010, 32'h5555_5555, 1'b0, 32'hFFFF_8001);
        idle();
        access(1'b0, 3'd4, 32'h0000_0001, 32'h0,        2, 32'h0000_F000, 4'b0010, 32'h0,        1'b0, 32'h0000_00F0);
        idle();
        access(1'b0, 3'd2, 32'h0000_0010, 32'h0,        0, 32'hCAFE_BABE, 4'b1111, 32'h0,        1'b0, 32'hCAFE_BABE);
        idle();

        // Back-to-back store then load with the request never dropped.
        txn_before = bus_txn;
        access(1'b1, 3'd2, 32'h0000_0020, 32'h1122_3344, 0, 32'h0,        4'b1111, 32'h1122_3344, 1'b0, 32'hCAFE_BABE);
        access(1'b0, 3'd2, 32'h0000_0020, 32'h0,        0, 32'h1122_3344, 4'b1111, 32'h0,        1'b0, 32'h1122_3344);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("b2b_txn_count", bus_txn - txn_before, 32'd2);

        // Reset between gnt and rvalid, followed by a stray rvalid.
        mem_auto = 1'b0;
        bus.data_gnt_i    = 1'b0;
        bus.data_rvalid_i = 1'b0;
        begin
            bus_exp_t b;
            b.we = 1'b0; b.addr = 32'h0000_0030; b.be = 4'b1111; b.wdata = '0; b.req_cycles = 1;
            bus_q.push_back(b);
        end
        bus.lsu_req_i  = 1'b1;
        bus.lsu_we_i   = 1'b0;
        bus.lsu_size_i = 3'd2;
        bus.lsu_addr_i = 32'h0000_0030;
        @(posedge clk);
        #1;
        bus.data_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        bus.data_gnt_i = 1'b0;
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        bus.lsu_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.data_rvalid_i = 1'b0;
        @(negedge clk);
        check("stray_lsu_data", bus.lsu_data_o, 32'd0);
        check("stray_data_req", {31'd0, bus.data_req_o}, 32'd0);
        check("stray_stall", {31'd0, bus.lsu_stall_req_o}, 32'd0);
        @(posedge clk);
        #1;
        mem_auto = 1'b1;
        @(posedge clk);
        #1;

        // A normal load afterwards proves the FSM came back to IDLE.
        access(1'b0, 3'd0, 32'h0000_0000, 32'h0,        0, 32'h0000_007F, 4'b0001, 32'h0,        1'b0, 32'h0000_007F);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("bus_q_empty", bus_q.size(), 32'd0);
        check("resp_q_empty", resp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
